// File: rtl/prio_encoder_8to3.sv
// Registered 8-to-3 priority encoder with sticky active-low request capture and a valid/ack grant handshake.
// Define ROUND_ROBIN_EN for rotating priority; by default the highest pending index always wins.
module prio_encoder_8to3 #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_n,
  input  logic         en,
  input  logic         ack,
  output logic [W-1:0] code,
  output logic         valid,
  output logic         multi,
  output logic [N-1:0] pend
);

  // Handshake: code is offered while valid=1 and held unchanged until the
  // consumer raises ack on a clock edge; that edge retires the grant, and
  // ack is ignored whenever valid=0.

  if (N < 2 || W != $clog2(N)) begin : g_bad_params
    $error("prio_encoder_8to3: need N>=2 and W == $clog2(N)");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   pend_q, pend_d;
  logic [W-1:0]   code_q, code_d;
  logic           multi_q, multi_d;
  logic [N-1:0]   clr;
  logic [N-1:0]   capt;
  logic [N-1:0]   code_oh_d;

`ifdef ROUND_ROBIN_EN
  logic [W-1:0]   last_idx_q, last_idx_d;

  // Search starts just below the last granted index and wraps, so the line
  // that was just served has the lowest priority on the next pick.
  function automatic logic [W-1:0] pick(input logic [N-1:0] p,
                                        input logic [W-1:0] last);
    logic [W-1:0] r;
    logic         found;
    int           idx;
    r     = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + N - k) % N;
      if (!found && p[idx]) begin
        r     = W'(idx);
        found = 1'b1;
      end
    end
    return r;
  endfunction
`else
  function automatic logic [W-1:0] pick(input logic [N-1:0] p);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (p[i]) r = W'(i);
    end
    return r;
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    clr     = '0;
`ifdef ROUND_ROBIN_EN
    last_idx_d = last_idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (|pend_q) begin
`ifdef ROUND_ROBIN_EN
          code_d = pick(pend_q, last_idx_q);
`else
          code_d = pick(pend_q);
`endif
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (ack) begin
          clr     = N'(1) << code_q;
          state_d = IDLE;
`ifdef ROUND_ROBIN_EN
          last_idx_d = code_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // A line still held low on the ack edge is re-captured, so set wins over clear.
    capt      = en ? ~req_n : '0;
    pend_d    = (pend_q & ~clr) | capt;
    code_oh_d = N'(1) << code_d;
    multi_d   = (state_d == GRANT) && (|(pend_d & ~code_oh_d));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      code_q  <= '0;
      multi_q <= 1'b0;
`ifdef ROUND_ROBIN_EN
      last_idx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      multi_q <= multi_d;
`ifdef ROUND_ROBIN_EN
      last_idx_q <= last_idx_d;
`endif
    end
  end

  assign code  = code_q;
  assign valid = (state_q == GRANT);
  assign multi = multi_q;
  assign pend  = pend_q;

endmodule

// File: tb/tb_prio_encoder_8to3.sv
// Bench for prio_encoder_8to3: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural grant model.
module tb_prio_encoder_8to3;
  localparam int N = 8;
  localparam int W = 3;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req_n = '1;
  logic         en = 1'b0;
  logic         ack = 1'b0;
  logic [W-1:0] code;
  logic         valid;
  logic         multi;
  logic [N-1:0] pend;

  always #5 clk = ~clk;

  prio_encoder_8to3 #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req_n (req_n),
    .en    (en),
    .ack   (ack),
    .code  (code),
    .valid (valid),
    .multi (multi),
    .pend  (pend)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [N-1:0] m_pend;
  int           m_code;
  int           m_last;
  bit           m_valid;
  bit           m_multi;

  function automatic int pick_model(input logic [N-1:0] p, input int last);
`ifdef ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last - k + N) % N;
      if (p[idx]) return idx;
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (p[i]) return i;
    end
`endif
    return 0;
  endfunction

  function automatic bit others_pending(input logic [N-1:0] p, input int c);
    int cnt;
    cnt = 0;
    for (int i = 0; i < N; i++) begin
      if (p[i] && i != c) cnt++;
    end
    return cnt > 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend  = '0;
      m_code  = 0;
      m_last  = 0;
      m_valid = 1'b0;
      m_multi = 1'b0;
    end else begin
      logic [N-1:0] np;
      np = m_pend;
      if (m_valid && ack) np[m_code] = 1'b0;
      if (en) np = np | ~req_n;
      if (m_valid) begin
        if (ack) begin
          m_valid = 1'b0;
          m_last  = m_code;
        end
      end else if (m_pend != 0) begin
        m_code  = pick_model(m_pend, m_last);
        m_valid = 1'b1;
      end
      m_pend  = np;
      m_multi = m_valid && others_pending(m_pend, m_code);
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        check("model_valid", 32'(valid), 32'(m_valid));
        check("model_code",  32'(code),  32'(m_code));
        check("model_multi", 32'(multi), 32'(m_multi));
        check("model_pend",  32'(pend),  32'(m_pend));
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a falling edge: applies inputs, then waits to the next falling edge.
  task automatic step(input logic [N-1:0] r, input logic e, input logic a);
    req_n = r;
    en    = e;
    ack   = a;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_n = '1;
    en    = 1'b0;
    ack   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int  budget;
    bit  done;
    budget = 0;
    done   = 1'b0;
    while (!done && budget < 50) begin
      if (valid) step('1, 1'b1, 1'b1);
      else if (pend != 0) step('1, 1'b1, 1'b0);
      else done = 1'b1;
      budget++;
    end
    check("drain_done", 32'(done), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int grants;
    int budget;
    @(negedge clk);
    apply_reset();
    check("rst_code",  32'(code),  32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_multi", 32'(multi), 32'd0);
    check("rst_pend",  32'(pend),  32'd0);

    // Priority: lines 7,4,0 pulsed once
    step(8'h6E, 1'b1, 1'b0);
    check("prio_pend", 32'(pend), 32'h91);
    step(8'hFF, 1'b1, 1'b0);
    check("prio_code7", 32'(code), 32'd7);
    check("prio_multi7", 32'(multi), 32'd1);
    step(8'hFF, 1'b1, 1'b1);
    check("prio_idle1", 32'(valid), 32'd0);
    check("prio_pend2", 32'(pend), 32'h11);
    step(8'hFF, 1'b1, 1'b0);
    check("prio_code4", 32'(code), 32'd4);
    check("prio_multi4", 32'(multi), 32'd1);
    step(8'hFF, 1'b1, 1'b1);
    check("prio_hold_code", 32'(code), 32'd4);
    check("prio_idle2", 32'(valid), 32'd0);
    step(8'hFF, 1'b1, 1'b0);
    check("prio_code0", 32'(code), 32'd0);
    check("prio_multi0", 32'(multi), 32'd0);
    step(8'hFF, 1'b1, 1'b1);
    check("prio_empty", 32'(pend), 32'd0);

    // No pre-emption, enable gating
    step(8'hF7, 1'b1, 1'b0);
    step(8'hFF, 1'b1, 1'b0);
    check("npe_code3", 32'(code), 32'd3);
    step(8'hBF, 1'b0, 1'b0);
    check("npe_en0_pend", 32'(pend), 32'h08);
    check("npe_en0_code", 32'(code), 32'd3);
    step(8'hBF, 1'b1, 1'b0);
    check("npe_en1_pend", 32'(pend), 32'h48);
    check("npe_en1_code", 32'(code), 32'd3);
    check("npe_en1_multi", 32'(multi), 32'd1);
    step(8'hFF, 1'b1, 1'b1);
    check("npe_ack_valid", 32'(valid), 32'd0);
    step(8'hFF, 1'b1, 1'b0);
    check("npe_code6", 32'(code), 32'd6);
    check("npe_valid6", 32'(valid), 32'd1);
    step(8'hFF, 1'b1, 1'b1);

    // Set wins over clear
    step(8'hFD, 1'b1, 1'b0);
    step(8'hFD, 1'b1, 1'b0);
    check("sw_code1", 32'(code), 32'd1);
    step(8'hFD, 1'b1, 1'b1);
    check("sw_pend_kept", 32'(pend), 32'h02);
    check("sw_valid0", 32'(valid), 32'd0);
    step(8'hFF, 1'b1, 1'b0);
    check("sw_regrant", 32'(code), 32'd1);
    check("sw_regrant_v", 32'(valid), 32'd1);
    step(8'hFF, 1'b1, 1'b1);
    drain();

    // Asynchronous reset in the middle of a grant of line 5
    step(8'hDF, 1'b1, 1'b0);
    step(8'hBF, 1'b1, 1'b0);
    check("ar_code5", 32'(code), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_code",  32'(code),  32'd0);
    check("ar_valid", 32'(valid), 32'd0);
    check("ar_multi", 32'(multi), 32'd0);
    check("ar_pend",  32'(pend),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request, latency
    step(8'hFB, 1'b1, 1'b0);
    check("single_pend", 32'(pend), 32'h04);
    check("single_not_yet", 32'(valid), 32'd0);
    step(8'hFF, 1'b1, 1'b0);
    check("single_valid", 32'(valid), 32'd1);
    check("single_code", 32'(code), 32'd2);
    check("single_multi", 32'(multi), 32'd0);
    step(8'hFF, 1'b1, 1'b1);
    check("single_done", 32'(valid), 32'd0);
    check("single_clr", 32'(pend), 32'd0);

    // All lines held low: fixed re-grants 7, round robin rotates
    apply_reset();
    for (int i = 0; i < 9; i++) begin
`ifdef ROUND_ROBIN_EN
      exp_q.push_back(W'((N - 1 - i + N) % N));
`else
      exp_q.push_back(W'(N - 1));
`endif
    end
    grants = 0;
    budget = 0;
    step(8'h00, 1'b1, 1'b0);
    while (grants < 9 && budget < 100) begin
      if (valid) begin
        check("all_low_code", 32'(code), 32'(exp_q.pop_front()));
        check("all_low_multi", 32'(multi), 32'd1);
        grants++;
        step(8'h00, 1'b1, 1'b1);
      end else begin
        step(8'h00, 1'b1, 1'b0);
      end
      budget++;
    end
    check("all_low_grants", 32'(grants), 32'd9);
    step(8'hFF, 1'b1, 1'b0);
    drain();

    // Randomized traffic, checked by the per-cycle compare
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] r;
      r = '1;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 5) == 0) r[b] = 1'b0;
      end
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        step(r, 1'b1, 1'b0);
        rst_n = 1'b1;
      end else begin
        step(r, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      end
    end
    step('1, 1'b1, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
